// File: rtl/bp_common_cfg_loader_pkg.sv
// Shared types for the config-ROM loader: FSM states, entry layout and terminator.
// Build option: BP_CFG_LOADER_READBACK_EN adds the read-back states.
`define BP_CFG_ENTRY_S(aw, dw) \
  typedef struct packed { \
    logic [(aw)-1:0] addr; \
    logic [(dw)-1:0] data; \
  } bp_cfg_entry_s;

package bp_common_cfg_loader_pkg;

  typedef enum logic [2:0] {
    e_idle,
    e_fetch,
    e_latch,
    e_send,
`ifdef BP_CFG_LOADER_READBACK_EN
    e_rd,
    e_rd_wait,
`endif
    e_next,
    e_done
  } bp_cfg_loader_state_e;

  // An all-ones address ends the ROM early; sliced to the config address width.
  localparam logic [63:0] cfg_term_addr_gp = '1;

endpackage

// File: rtl/bp_cfg_loader_counter.sv
// Saturating index counter with synchronous clear/step and a last-value flag.
module bp_cfg_loader_counter #(
  parameter int width_p = 4,
  parameter int max_p   = 15
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               step_i,
  output logic [width_p-1:0] count_o,
  output logic               last_o
);
  localparam logic [width_p-1:0] lp_max = width_p'(max_p);

  logic [width_p-1:0] r_count;

  // Never steps past max_p, so the caller's last-index compare is the only exit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (step_i && !last_o) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count_o = r_count;
  assign last_o  = (r_count == lp_max);

endmodule

// File: rtl/bp_cfg_loader.sv
// Walks the config ROM and broadcasts each (addr, data) entry to every core.
// Build option: BP_CFG_LOADER_READBACK_EN reads each register back and flags mismatches.
module bp_cfg_loader
  import bp_common_cfg_loader_pkg::*;
#(
  parameter int num_core_p       = 2,
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int num_entries_p    = 16,
  localparam int lg_entries_lp   = (num_entries_p > 1) ? $clog2(num_entries_p) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic                                     start_i,
  output logic [lg_entries_lp-1:0]                 rom_addr_o,
  input  logic [cfg_addr_width_p+cfg_data_width_p-1:0] rom_data_i,
  output logic                                     cfg_v_o,
  output logic                                     cfg_w_o,
  output logic [cfg_core_width_p-1:0]              cfg_core_o,
  output logic [cfg_addr_width_p-1:0]              cfg_addr_o,
  output logic [cfg_data_width_p-1:0]              cfg_data_o,
  input  logic                                     cfg_ready_i,
  input  logic                                     cfg_resp_v_i,
  input  logic [cfg_data_width_p-1:0]              cfg_resp_data_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     error_o
);
  `BP_CFG_ENTRY_S(cfg_addr_width_p, cfg_data_width_p)

  localparam logic [cfg_addr_width_p-1:0] lp_term_addr = cfg_term_addr_gp[cfg_addr_width_p-1:0];

  bp_cfg_loader_state_e          r_state;
  logic [cfg_addr_width_p-1:0]   r_addr;
  logic [cfg_data_width_p-1:0]   r_data;
  logic [cfg_data_width_p-1:0]   r_cfg_data;
  logic                          r_cfg_v, r_cfg_w, r_busy, r_done;
  bp_cfg_entry_s                 w_rom_entry;
  logic [lg_entries_lp-1:0]      w_entry;
  logic [cfg_core_width_p-1:0]   w_core;
  logic                          w_entry_last, w_core_last, w_start, w_in_next;

  assign w_rom_entry = rom_data_i;
  assign w_start     = (r_state == e_idle) && start_i;
  assign w_in_next   = (r_state == e_next);

  bp_cfg_loader_counter #(.width_p(lg_entries_lp), .max_p(num_entries_p-1)) u_entry_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (w_start),
    .step_i    (w_in_next && w_core_last),
    .count_o   (w_entry),
    .last_o    (w_entry_last)
  );

  bp_cfg_loader_counter #(.width_p(cfg_core_width_p), .max_p(num_core_p-1)) u_core_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (w_start || (w_in_next && w_core_last)),
    .step_i    (w_in_next),
    .count_o   (w_core),
    .last_o    (w_core_last)
  );

`ifdef BP_CFG_LOADER_READBACK_EN
  logic r_error;
  assign error_o = r_error;
`else
  logic w_unused;
  assign w_unused = ^{cfg_resp_v_i, cfg_resp_data_i};
  assign error_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= e_idle;
      r_addr     <= '0;
      r_data     <= '0;
      r_cfg_data <= '0;
      r_cfg_v    <= 1'b0;
      r_cfg_w    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef BP_CFG_LOADER_READBACK_EN
      r_error    <= 1'b0;
`endif
    end else begin
      case (r_state)
        e_idle: if (start_i) begin
          r_done  <= 1'b0;
          r_busy  <= 1'b1;
`ifdef BP_CFG_LOADER_READBACK_EN
          r_error <= 1'b0;
`endif
          r_state <= e_fetch;
        end
        e_fetch: r_state <= e_latch;
        e_latch: begin
          r_addr <= w_rom_entry.addr;
          r_data <= w_rom_entry.data;
          if (w_rom_entry.addr == lp_term_addr) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= e_done;
          end else begin
            r_cfg_v    <= 1'b1;
            r_cfg_w    <= 1'b1;
            r_cfg_data <= w_rom_entry.data;
            r_state    <= e_send;
          end
        end
        e_send: if (cfg_ready_i) begin
          r_cfg_w    <= 1'b0;
          r_cfg_data <= '0;
`ifdef BP_CFG_LOADER_READBACK_EN
          r_state    <= e_rd;
`else
          r_cfg_v    <= 1'b0;
          r_state    <= e_next;
`endif
        end
`ifdef BP_CFG_LOADER_READBACK_EN
        e_rd: if (cfg_ready_i) begin
          r_cfg_v <= 1'b0;
          r_state <= e_rd_wait;
        end
        e_rd_wait: if (cfg_resp_v_i) begin
          if (cfg_resp_data_i != r_data) r_error <= 1'b1;
          r_state <= e_next;
        end
`endif
        e_next: begin
          if (!w_core_last) begin
            r_cfg_v    <= 1'b1;
            r_cfg_w    <= 1'b1;
            r_cfg_data <= r_data;
            r_state    <= e_send;
          end else if (w_entry_last) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= e_done;
          end else begin
            r_state <= e_fetch;
          end
        end
        e_done: r_state <= e_idle;
        default: r_state <= e_idle;
      endcase
    end
  end

  assign rom_addr_o = w_entry;
  assign cfg_v_o    = r_cfg_v;
  assign cfg_w_o    = r_cfg_w;
  assign cfg_core_o = w_core;
  assign cfg_addr_o = r_addr;
  assign cfg_data_o = r_cfg_data;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule
